// File: rtl/tt_um_mem.sv
// rtl/tt_um_mem.sv - 8-word x 16-bit flip-flop memory behind the 8/8/8 pin wrapper
//
// Purpose:
//   Small register-file memory. The word address and the active-low write
//   enable come from two internal control registers, adrforce and weforce.
//   No pins are spare for them, so they are set by hierarchical assignment
//   from outside. Only reset touches them inside this module.
//
// Ports:
//   clk      in   1  system clock, rising-edge active
//   rst_n    in   1  asynchronous reset, active HIGH (name kept from the wrapper)
//   ena      in   1  design-powered indicator, unused
//   ui_in    in   8  write data [7:0]
//   uio_in   in   8  write data [15:8]
//   uo_out   out  8  read data [7:0]
//   uio_out  out  8  read data [15:8]
//   uio_oe   out  8  uio pin direction, 1 = output (0x00 while writing)
//
// Build option:
//   READ_REG_EN  when defined, read data passes through a 16-bit output
//                register, which gives one cycle of read latency. When it is
//                not defined, the read path is combinational.

module tt_um_mem (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int DEPTH = 8;
  localparam int WIDTH = 16;
  localparam int AW    = 3;

  // Control registers. These names are part of the external contract.
  logic [AW-1:0] adrforce;
  logic          weforce;   // 0 = write, 1 = read

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] wr_word;
  logic [WIDTH-1:0] rd_word;
  logic [WIDTH-1:0] rd_out;

  // ena is part of the wrapper but carries no meaning here.
  logic unused_ena;
  assign unused_ena = ena;

  // The reset branch is the only in-module writer. There is deliberately no
  // else branch, so a value placed in these registers from outside stays
  // there until the next reset.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      adrforce <= '0;
      weforce  <= 1'b1;
    end
  end

  assign wr_word = {uio_in, ui_in};

  // Next-state for the array. Only the addressed word changes, and only
  // while weforce is low.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (!weforce) begin
      mem_d[adrforce] = wr_word;
    end
  end

  // Reset clears the whole array immediately, so a write that is pending
  // when reset rises never lands.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Every 3-bit address selects a real word, so no range guard is needed.
  assign rd_word = mem_q[adrforce];

`ifdef READ_REG_EN
  logic [WIDTH-1:0] rdata_q;
  logic [WIDTH-1:0] rdata_d;

  // The register samples the pre-edge array contents. A word written at
  // edge N therefore reaches the pins at edge N+1.
  assign rdata_d = rd_word;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rd_out = rdata_q;
`else
  assign rd_out = rd_word;
`endif

  assign uo_out  = rd_out[7:0];
  assign uio_out = rd_out[15:8];

  // The direction follows weforce directly in both builds. While writing, the
  // uio pins carry the high data byte into the block.
  assign uio_oe = weforce ? 8'hFF : 8'h00;

endmodule

// File: tb/tb_tt_um_mem.sv
// tb/tb_tt_um_mem.sv - self-checking bench for tt_um_mem
module tb_tt_um_mem;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: a plain array of words, the current address and the
  // write-enable level, plus the registered read value for READ_REG_EN.
  logic [15:0] m_mem [8];
  logic [2:0]  m_adr;
  logic        m_we;
  logic [15:0] m_rd;

  tt_um_mem dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_out();
`ifdef READ_REG_EN
    return m_rd;
`else
    return m_mem[m_adr];
`endif
  endfunction

  // Model clock edge: the read register samples first, then the write lands.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_rd = m_mem[m_adr];
      if (!m_we) m_mem[m_adr] = {uio_in, ui_in};
    end
  end

  // Per-cycle compare, away from the active edge.
  always @(negedge clk) begin
    chk("cycle_data", {16'h0, uio_out, uo_out}, {16'h0, model_out()});
    chk("cycle_oe", {24'h0, uio_oe}, {24'h0, (m_we ? 8'hFF : 8'h00)});
  end

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_mem[i] = 16'h0;
    m_adr = 3'd0;
    m_we  = 1'b1;
    m_rd  = 16'h0;
  endtask

  task automatic set_ctrl(input logic [2:0] adr, input logic we);
    dut.adrforce = adr;
    dut.weforce  = we;
    m_adr = adr;
    m_we  = we;
  endtask

  // Inputs change just after a falling edge, after the compare has sampled.
  task automatic to_drive();
    @(negedge clk);
    #1;
  endtask

  task automatic write_word(input logic [2:0] adr, input logic [15:0] d);
    to_drive();
    set_ctrl(adr, 1'b0);
    {uio_in, ui_in} = d;
    @(posedge clk);
    #1;
  endtask

  task automatic read_check(input string name, input logic [2:0] adr, input logic [15:0] exp);
    to_drive();
    set_ctrl(adr, 1'b1);
`ifdef READ_REG_EN
    @(posedge clk);
`endif
    #1;
    chk(name, {16'h0, uio_out, uo_out}, {16'h0, exp});
  endtask

  initial begin
    model_reset();
    rst_n  = 1'b1;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;

    // Hold reset for two cycles, then release it.
    @(posedge clk);
    @(posedge clk);
    to_drive();
    rst_n = 1'b0;
    #1;
    chk("rst_uo", {24'h0, uo_out}, 32'h00);
    chk("rst_uio_out", {24'h0, uio_out}, 32'h00);
    chk("rst_oe", {24'h0, uio_oe}, 32'hFF);
    chk("rst_adr", {29'h0, dut.adrforce}, 32'd0);
    chk("rst_we", {31'h0, dut.weforce}, 32'd1);

    // Write 0x1253 to address 3.
    to_drive();
    set_ctrl(3'd3, 1'b0);
    ui_in  = 8'h53;
    uio_in = 8'h12;
    #1;
    chk("wr_oe", {24'h0, uio_oe}, 32'h00);
    @(posedge clk);
    #1;
`ifdef READ_REG_EN
    chk("reg_lat_at_edge", {16'h0, uio_out, uo_out}, 32'h0000);
`else
    chk("wr3_uo", {24'h0, uo_out}, 32'h53);
    chk("wr3_uio", {24'h0, uio_out}, 32'h12);
`endif

    // Switch to read and drive 0xFFFF for three edges; the stored word must not change.
    to_drive();
    set_ctrl(3'd3, 1'b1);
    ui_in  = 8'hFF;
    uio_in = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    chk("hold_1253", {16'h0, uio_out, uo_out}, 32'h1253);
    chk("hold_oe", {24'h0, uio_oe}, 32'hFF);

    // Write and read the boundary addresses, and confirm an untouched word.
    write_word(3'd0, 16'hA5A5);
    write_word(3'd7, 16'h5A5A);
    read_check("rd0", 3'd0, 16'hA5A5);
    read_check("rd7", 3'd7, 16'h5A5A);
    read_check("rd4", 3'd4, 16'h0000);
    read_check("rd3", 3'd3, 16'h1253);

    // Two writes to one address: the later edge wins.
    write_word(3'd5, 16'h1111);
    write_word(3'd5, 16'h2222);
    read_check("rd5_last", 3'd5, 16'h2222);

    // Reset arrives between edges while a write to address 2 is pending.
    to_drive();
    set_ctrl(3'd2, 1'b0);
    {uio_in, ui_in} = 16'hAAAA;
    #1;
    {uio_in, ui_in} = 16'hBBBB;
    #1;
    rst_n = 1'b1;
    model_reset();
    #1;
    chk("mid_rst_data", {16'h0, uio_out, uo_out}, 32'h0000);
    chk("mid_rst_oe", {24'h0, uio_oe}, 32'hFF);
    chk("mid_rst_we", {31'h0, dut.weforce}, 32'd1);
    chk("mid_rst_adr", {29'h0, dut.adrforce}, 32'd0);
    @(posedge clk);
    #1;
    chk("rst_edge_data", {16'h0, uio_out, uo_out}, 32'h0000);
    to_drive();
    rst_n = 1'b0;
    read_check("rd2_cleared", 3'd2, 16'h0000);
    read_check("rd3_cleared", 3'd3, 16'h0000);
    read_check("rd0_cleared", 3'd0, 16'h0000);

    // Write 0x1253 to address 3 again and follow it through the edges.
    to_drive();
    set_ctrl(3'd3, 1'b0);
    {uio_in, ui_in} = 16'h1253;
    @(posedge clk);
    #1;
    to_drive();
    set_ctrl(3'd3, 1'b1);
`ifdef READ_REG_EN
    #1;
    chk("reg_not_yet", {16'h0, uio_out, uo_out}, 32'h0000);
    @(posedge clk);
    #1;
    chk("reg_next_edge", {16'h0, uio_out, uo_out}, 32'h1253);
`else
    #1;
    chk("comb_readback", {16'h0, uio_out, uo_out}, 32'h1253);
`endif

    repeat (2) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tt_um_mem.md
Name: tt_um_mem

Overview:
- Flip-flop-based 8-word x 16-bit memory behind the standard 8-in / 8-out / 8-bidir pin wrapper used across the codebase.
- Write data enters on ui_in (low byte) and uio_in (high byte); read data leaves on uo_out (low byte) and uio_out (high byte).
- Address and write-enable come from two internal control registers, adrforce and weforce. The bench drives them by hierarchical assignment; no pins are spare for them.

Parameters:
- DEPTH, 8, number of words; fixed at 8, so the address is 3 bits.
- WIDTH, 16, word width; fixed at 16 (ui_in plus uio_in).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-high reset. Asserted when 1. Name kept per wrapper convention.
- ena  input  1  design-powered indicator; ignored.
- ui_in  input  8  write data bits [7:0].
- uio_in  input  8  write data bits [15:8].
- uo_out  output  8  read data bits [7:0].
- uio_out  output  8  read data bits [15:8].
- uio_oe  output  8  bidirectional-pin enables; 1 means output.

Behaviour:
- Internal state:
  - mem[0..7], each 16 bits.
  - adrforce, a 3-bit register.
  - weforce, a 1-bit register, active-low write enable: 0 = write, 1 = read.
  - Both control registers use these exact names at top level, so a bench can assign them hierarchically.
- Reset (rst_n = 1, asynchronous, takes effect immediately):
  - all mem words = 16'h0000.
  - adrforce = 3'd0, weforce = 1.
  - uo_out = 8'h00, uio_out = 8'h00, uio_oe = 8'hFF.
- While reset is asserted, no writes occur, whatever weforce holds.
- Control registers:
  - No logic other than reset changes adrforce or weforce. They hold their value across clocks.
  - Any value placed in them, including by hierarchical assignment, persists until reset.
- Write, when reset is deasserted and weforce = 0: on each rising clk edge, mem[adrforce] <= {uio_in, ui_in}. Zero-latency capture at that edge.
- Read: {uio_out, uo_out} = mem[adrforce], combinational. A changed adrforce or a completed write appears at the outputs in the same cycle.
- Read-during-write: before the write edge, the outputs show the old word; after the edge, the new word.
- uio_oe = 8'h00 when weforce = 0 (uio pins act as data inputs); 8'hFF when weforce = 1 (uio pins drive the high read byte).
- Address range is 0..7 with no out-of-range case; every 3-bit value selects a word.
- Repeated writes to the same address: the last edge wins.
- Reset asserted mid-write: the write is aborted and the memory is cleared. After deassertion the block comes up in read mode at address 0.
- ena has no effect.

Optional Feature:
- Macro: READ_REG_EN.
- Defined:
  - Read data passes through a 16-bit output register loaded on each rising clk edge with mem[adrforce], giving 1-cycle read latency.
  - A write becomes visible 1 cycle after the write edge.
  - The output register resets to 0.
  - uio_oe stays combinational from weforce.
- Not defined: read path is purely combinational, as in Behaviour.

Test Plan:
- Assert rst_n = 1 for 2 cycles, then 0 -> uo_out = 8'h00, uio_out = 8'h00, uio_oe = 8'hFF; adrforce = 0, weforce = 1.
- Set adrforce = 3, weforce = 0, ui_in = 8'h53, uio_in = 8'h12, then one clk edge -> mem[3] = 16'h1253; uo_out = 8'h53, uio_out = 8'h12; uio_oe = 8'h00.
- Then set weforce = 1 and change the inputs to 16'hFFFF for 3 edges -> outputs stay 16'h1253 and uio_oe = 8'hFF.
- Write 16'hA5A5 to address 0 and 16'h5A5A to address 7, then read addresses 0, 7 and 4 -> 16'hA5A5, 16'h5A5A, 16'h0000.
- With weforce = 0 at address 2, change the input data mid-cycle; assert rst_n = 1 between edges -> outputs go to 0 immediately; mem[2] = 16'h0000; weforce = 1; uio_oe = 8'hFF.
- With READ_REG_EN defined, write 16'h1253 to address 3 and read it back -> the value appears at the outputs one clk edge after the write edge, not at it.
